// File: rtl/toy_cpu_core.sv
// Single-cycle accumulator CPU: A/B registers, carry flag, output register and halt.
// Fetches one instruction per enabled clock from an external combinational ROM.
module toy_cpu_core #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned PC_W   = 4
) (
  input  logic              CK,
  input  logic              RST_N,
  input  logic              EN,
  output logic [PC_W-1:0]   IADDR,
  input  logic [DATA_W+3:0] IDATA,
  input  logic [DATA_W-1:0] IN_PORT,
  output logic [DATA_W-1:0] OUT_PORT,
  output logic              CARRY,
  output logic              HALT,
  output logic [DATA_W-1:0] A_OUT,
  output logic [DATA_W-1:0] B_OUT
);

  typedef enum logic [3:0] {
    OpAddAIm = 4'h0,
    OpMovAB  = 4'h1,
    OpInA    = 4'h2,
    OpMovAIm = 4'h3,
    OpMovBA  = 4'h4,
    OpAddBIm = 4'h5,
    OpInB    = 4'h6,
    OpMovBIm = 4'h7,
    OpAddAB  = 4'h8,
    OpOutB   = 4'h9,
    OpHlt    = 4'hA,
    OpOutIm  = 4'hB,
    OpJc     = 4'hC,
    OpNop    = 4'hD,
    OpJnc    = 4'hE,
    OpJmp    = 4'hF
  } op_e;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic              c_q, c_d, halt_q, halt_d;

  op_e               op;
  logic [DATA_W-1:0] imm;
  logic [PC_W-1:0]   jmp_tgt;
  logic [DATA_W:0]   sum;

  assign op      = op_e'(IDATA[DATA_W+3:DATA_W]);
  assign imm     = IDATA[DATA_W-1:0];
  assign jmp_tgt = imm[PC_W-1:0];

  always_comb begin
    pc_d   = pc_q;
    a_d    = a_q;
    b_d    = b_q;
    out_d  = out_q;
    c_d    = c_q;
    halt_d = halt_q;
    sum    = '0;
    // Once halted nothing moves until reset, whatever EN or IDATA do.
    if (EN && !halt_q) begin
      pc_d = pc_q + PC_W'(1);
      unique case (op)
        OpAddAIm: begin
          sum = {1'b0, a_q} + {1'b0, imm};
          a_d = sum[DATA_W-1:0];
          c_d = sum[DATA_W];
        end
        OpMovAB:  a_d = b_q;
        OpInA:    a_d = IN_PORT;
        OpMovAIm: a_d = imm;
        OpMovBA:  b_d = a_q;
        OpAddBIm: begin
          sum = {1'b0, b_q} + {1'b0, imm};
          b_d = sum[DATA_W-1:0];
          c_d = sum[DATA_W];
        end
        OpInB:    b_d = IN_PORT;
        OpMovBIm: b_d = imm;
        OpAddAB: begin
          sum = {1'b0, a_q} + {1'b0, b_q};
          a_d = sum[DATA_W-1:0];
          c_d = sum[DATA_W];
        end
        OpOutB:   out_d = b_q;
        OpHlt: begin
          pc_d   = pc_q;
          halt_d = 1'b1;
        end
        OpOutIm:  out_d = imm;
        OpJc:     if (c_q) pc_d = jmp_tgt;
        OpNop:    ;
        OpJnc:    if (!c_q) pc_d = jmp_tgt;
        OpJmp:    pc_d = jmp_tgt;
      endcase
    end
  end

  always_ff @(posedge CK) begin
    if (!RST_N) begin
      pc_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      out_q  <= '0;
      c_q    <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      out_q  <= out_d;
      c_q    <= c_d;
      halt_q <= halt_d;
    end
  end

  assign IADDR    = pc_q;
  assign OUT_PORT = out_q;
  assign CARRY    = c_q;
  assign HALT     = halt_q;
  assign A_OUT    = a_q;
  assign B_OUT    = b_q;

endmodule

// File: tb/tb_toy_cpu_core.sv
// Bench for toy_cpu_core: directed programs plus randomized ROM/EN/IN_PORT/reset,
// checked every cycle against an instruction-level model; an 8/6-bit instance covers width.
module tb_toy_cpu_core;

  logic       ck = 1'b0;
  logic       rst_n, en;
  logic [3:0] iaddr, in_port, out_port, a_out, b_out;
  logic [7:0] idata;
  logic       carry, halt;
  logic [7:0] rom [16];

  logic        rst_n_w, en_w;
  logic [5:0]  iaddr_w;
  logic [11:0] idata_w;
  logic [7:0]  in_port_w, out_port_w, a_out_w, b_out_w;
  logic        carry_w, halt_w;
  logic [11:0] rom_w [64];

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural state of the reference model.
  int m_pc, m_a, m_b, m_out, m_c, m_halt;

  always #5 ck = ~ck;

  assign idata   = rom[iaddr];
  assign idata_w = rom_w[iaddr_w];

  toy_cpu_core #(.DATA_W(4), .PC_W(4)) dut (
    .CK(ck), .RST_N(rst_n), .EN(en), .IADDR(iaddr), .IDATA(idata), .IN_PORT(in_port),
    .OUT_PORT(out_port), .CARRY(carry), .HALT(halt), .A_OUT(a_out), .B_OUT(b_out)
  );

  toy_cpu_core #(.DATA_W(8), .PC_W(6)) dut_w (
    .CK(ck), .RST_N(rst_n_w), .EN(en_w), .IADDR(iaddr_w), .IDATA(idata_w),
    .IN_PORT(in_port_w), .OUT_PORT(out_port_w), .CARRY(carry_w), .HALT(halt_w),
    .A_OUT(a_out_w), .B_OUT(b_out_w)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One instruction at the ISA level: sums computed as integers, carry = sum > 15.
  task automatic model_step(input bit e, input bit r);
    int op, im, s;
    if (!r) begin
      m_pc = 0; m_a = 0; m_b = 0; m_out = 0; m_c = 0; m_halt = 0;
    end else if (e && m_halt == 0) begin
      op = rom[m_pc] >> 4;
      im = rom[m_pc] % 16;
      s  = -1;
      m_pc = (m_pc + 1) % 16;
      case (op)
        0:  s = m_a + im;
        1:  m_a = m_b;
        2:  m_a = in_port;
        3:  m_a = im;
        4:  m_b = m_a;
        5:  begin m_b = (m_b + im) % 16; m_c = (m_b < im) ? 1 : 0; end
        6:  m_b = in_port;
        7:  m_b = im;
        8:  s = m_a + m_b;
        9:  m_out = m_b;
        10: begin m_halt = 1; m_pc = (m_pc + 15) % 16; end
        11: m_out = im;
        12: if (m_c == 1) m_pc = im;
        14: if (m_c == 0) m_pc = im;
        15: m_pc = im;
        default: ;
      endcase
      if (s >= 0) begin
        m_a = s % 16;
        m_c = (s > 15) ? 1 : 0;
      end
    end
  endtask

  // Drive inputs, clock once, compare every architectural output to the model.
  task automatic tick(input bit e, input bit r);
    en = e;
    rst_n = r;
    model_step(e, r);
    @(posedge ck);
    #1;
    check_eq("pc", iaddr, m_pc);
    check_eq("a", a_out, m_a);
    check_eq("b", b_out, m_b);
    check_eq("out", out_port, m_out);
    check_eq("c", carry, m_c);
    check_eq("halt", halt, m_halt);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; in_port = '0;
    rst_n_w = 1'b0; en_w = 1'b1; in_port_w = '0;
    for (int i = 0; i < 16; i++) rom[i] = 8'hD0;
    for (int i = 0; i < 64; i++) rom_w[i] = 12'hD00;

    // Carry / jumps, with a reset in the middle of the run.
    rom[0] = 8'h33; rom[1] = 8'h0E; rom[2] = 8'hE0; rom[3] = 8'hC7;
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
    do_reset();
    check_eq("rst_pc", iaddr, 0);
    check_eq("rst_a", a_out, 0);
    check_eq("rst_b", b_out, 0);
    check_eq("rst_out", out_port, 0);
    check_eq("rst_c", carry, 0);
    check_eq("rst_halt", halt, 0);
    tick(1'b1, 1'b1);
    check_eq("mov_a_pc", iaddr, 1);
    check_eq("mov_a", a_out, 3);
    tick(1'b1, 1'b1);
    check_eq("add_pc", iaddr, 2);
    check_eq("add_a", a_out, 1);
    check_eq("add_c", carry, 1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    check_eq("stall_pc", iaddr, 2);
    check_eq("stall_a", a_out, 1);
    tick(1'b1, 1'b1);
    check_eq("jnc_fall", iaddr, 3);
    tick(1'b1, 1'b1);
    check_eq("jc_taken", iaddr, 7);

    // Input port, register add, stall on IN.
    rom[0] = 8'h20; rom[1] = 8'h41; rom[2] = 8'h80; rom[3] = 8'h90; rom[4] = 8'h01;
    for (int i = 5; i < 16; i++) rom[i] = 8'hD0;
    in_port = 4'd9;
    do_reset();
    in_port = 4'd4;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    check_eq("in_stall_a", a_out, 0);
    in_port = 4'd9;
    tick(1'b1, 1'b1);
    check_eq("in_a", a_out, 9);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    check_eq("addab_a", a_out, 2);
    check_eq("addab_c", carry, 1);
    check_eq("addab_b", b_out, 9);
    tick(1'b1, 1'b1);
    check_eq("out_b", out_port, 9);
    tick(1'b1, 1'b1);
    check_eq("add1_a", a_out, 3);
    check_eq("add1_c", carry, 0);

    // Halt: frozen regardless of EN and IN_PORT until reset.
    rom[0] = 8'hB5; rom[1] = 8'hA0;
    do_reset();
    tick(1'b1, 1'b1);
    check_eq("out_im", out_port, 5);
    tick(1'b1, 1'b1);
    check_eq("halt_set", halt, 1);
    for (int i = 0; i < 10; i++) begin
      in_port = 4'(i);
      tick(1'(i % 2), 1'b1);
      check_eq("halt_pc", iaddr, 1);
    end
    tick(1'b1, 1'b0);
    check_eq("halt_clr", halt, 0);

    // PC wrap: ADD B,1 at the last address runs once per 16 cycles.
    for (int i = 0; i < 16; i++) rom[i] = 8'hD0;
    rom[15] = 8'h51;
    do_reset();
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b1);
    check_eq("wrap_pc15", iaddr, 15);
    tick(1'b1, 1'b1);
    check_eq("wrap_pc0", iaddr, 0);
    check_eq("wrap_b1", b_out, 1);
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b1);
    check_eq("wrap_b2", b_out, 2);

    // Randomized programs, enables, inputs and occasional resets.
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) rom[$urandom_range(0, 15)] = 8'($urandom);
      in_port = 4'($urandom);
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 39) != 0);
    end

    // Wide instance: 8-bit data, 6-bit PC.
    rom_w[0] = {4'h3, 8'd200};
    rom_w[1] = {4'h0, 8'd100};
    rom_w[2] = {4'hF, 8'hC5};
    en = 1'b0;
    rst_n_w = 1'b0;
    @(posedge ck); #1;
    check_eq("w_rst_pc", iaddr_w, 0);
    rst_n_w = 1'b1;
    @(posedge ck); #1;
    check_eq("w_mov_a", a_out_w, 200);
    @(posedge ck); #1;
    check_eq("w_add_a", a_out_w, 44);
    check_eq("w_add_c", carry_w, 1);
    @(posedge ck); #1;
    check_eq("w_jmp_pc", iaddr_w, 6'h05);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
